// File: rtl/lc4_memory_pipelined.sv
// lc4_memory_pipelined
//   Instruction/data memory for the pipelined LC4 core.
//   - NUM_IPORTS instruction read ports. Each port has an INSN_LATENCY-deep,
//     valid-tagged delay line that models a slow instruction store.
//   - One instruction load port, which writes imem with read-before-write.
//   - One data port, with a combinational read and a clocked write.
//   - All state advances only when gwe=1. rst (synchronous, active high)
//     clears the delay lines regardless of gwe. The memory arrays are never
//     cleared.
//
// Ports
//   idclk            clock, rising edge
//   rst              synchronous active-high reset of the delay lines
//   gwe              global write enable
//   ire/iaddr        per-port read request/address (port k at [k*IADDR_W +: IADDR_W])
//   iout/ivalid      per-port instruction/valid (port k at [k*INSN_W +: INSN_W])
//   lwe/lwaddr/lwdata  instruction load port
//   dre/draddr/dout    data read port
//   dwe/dwaddr/din     data write port
//   iflush           (only with LC4_MEMORY_IFLUSH_EN) zero stages 1..L-1 on all ports
//
// Optional feature macro: LC4_MEMORY_IFLUSH_EN
module lc4_memory_pipelined #(
    parameter int WORD_SIZE    = 16,
    parameter int INSN_W       = 20,
    parameter int IADDR_W      = 11,
    parameter int DADDR_W      = 5,
    parameter int NUM_IPORTS   = 2,
    parameter int INSN_LATENCY = 8
) (
    input  logic                          idclk,
    input  logic                          rst,
    input  logic                          gwe,
    input  logic [NUM_IPORTS-1:0]         ire,
    input  logic [NUM_IPORTS*IADDR_W-1:0] iaddr,
    output logic [NUM_IPORTS*INSN_W-1:0]  iout,
    output logic [NUM_IPORTS-1:0]         ivalid,
    input  logic                          lwe,
    input  logic [IADDR_W-1:0]            lwaddr,
    input  logic [INSN_W-1:0]             lwdata,
    input  logic                          dre,
    input  logic [DADDR_W-1:0]            draddr,
    output logic [WORD_SIZE-1:0]          dout,
    input  logic                          dwe,
    input  logic [DADDR_W-1:0]            dwaddr,
    input  logic [WORD_SIZE-1:0]          din
`ifdef LC4_MEMORY_IFLUSH_EN
    ,
    input  logic                          iflush
`endif
);

    // A zero-latency build still declares one (unused) stage so that the
    // per-port structure does not depend on the latency value.
    localparam int STAGES = (INSN_LATENCY == 0) ? 1 : INSN_LATENCY;
    localparam int LAST   = STAGES - 1;
    localparam int IDEPTH = 1 << IADDR_W;
    localparam int DDEPTH = 1 << DADDR_W;

    logic [INSN_W-1:0]    imem_r [IDEPTH];
    logic [WORD_SIZE-1:0] dmem_r [DDEPTH];
    logic                 flush_s;

`ifdef LC4_MEMORY_IFLUSH_EN
    assign flush_s = iflush;
`else
    assign flush_s = 1'b0;
`endif

    // Instruction load port. Port reads in the same cycle see the old word.
    always_ff @(posedge idclk) begin
        if (gwe && lwe) begin
            imem_r[lwaddr] <= lwdata;
        end
    end

    // Data write port. A same-cycle read returns the old word.
    always_ff @(posedge idclk) begin
        if (gwe && dwe) begin
            dmem_r[dwaddr] <= din;
        end
    end

    // Combinational data read. It is forced to zero when no read is requested.
    always_comb begin
        dout = {WORD_SIZE{1'b0}};
        if (dre) begin
            dout = dmem_r[draddr];
        end else begin
            dout = {WORD_SIZE{1'b0}};
        end
    end

    for (genvar k = 0; k < NUM_IPORTS; k++) begin : g_port
        logic [IADDR_W-1:0] addr_s;
        logic [INSN_W-1:0]  rd_s;
        logic [INSN_W-1:0]  data_r [STAGES];
        logic [STAGES-1:0]  valid_r;

        assign addr_s = iaddr[k*IADDR_W +: IADDR_W];

        // The array read is masked, so an idle slot always carries zero data.
        always_comb begin
            rd_s = {INSN_W{1'b0}};
            if (ire[k]) begin
                rd_s = imem_r[addr_s];
            end else begin
                rd_s = {INSN_W{1'b0}};
            end
        end

        // Delay line. Stage 0 always captures the current request, even
        // during a flush. A flush empties only the older stages.
        always_ff @(posedge idclk) begin
            if (rst) begin
                for (int s = 0; s < STAGES; s++) begin
                    data_r[s] <= {INSN_W{1'b0}};
                end
                valid_r <= {STAGES{1'b0}};
            end else if (gwe) begin
                data_r[0]  <= rd_s;
                valid_r[0] <= ire[k];
                for (int s = 1; s < STAGES; s++) begin
                    if (flush_s) begin
                        data_r[s]  <= {INSN_W{1'b0}};
                        valid_r[s] <= 1'b0;
                    end else begin
                        data_r[s]  <= data_r[s-1];
                        valid_r[s] <= valid_r[s-1];
                    end
                end
            end
        end

        // With zero latency the masked read goes straight to the output.
        // Otherwise the output comes from the last stage of the delay line.
        assign iout[k*INSN_W +: INSN_W] = (INSN_LATENCY == 0) ? rd_s : data_r[LAST];
        assign ivalid[k]                = (INSN_LATENCY == 0) ? ire[k] : valid_r[LAST];
    end

endmodule
